// File: rtl/bit_serializer_if.sv
// Handshake and serial-output bundle for bit_serializer.
// The master drives parallel words in; the slave (the serializer) presents the serial stream.
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic [15:0]      words_sent;

    modport master (
        output din, din_valid,
        input  din_ready, ser_out, ser_valid, frame_start, words_sent
    );

    modport slave (
        input  din, din_valid,
        output din_ready, ser_out, ser_valid, frame_start, words_sent
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one bit per clock, a one-entry holding register
// for back-to-back streaming, optional inter-word gap and a completed-word counter.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0,
    parameter int GAP       = 0
) (
    input  logic                clk,
    input  logic                reset,
    bit_serializer_if.slave     bus
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [3:0]       GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             frame_start_q, frame_start_d;
    logic [15:0]      words_sent_q, words_sent_d;

    logic             accept_s;
    logic             load_s;
    logic             load_din_s;
    logic             take_hold_s;
    logic [WIDTH-1:0] load_word_s;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) begin
            return w[WIDTH-1];
        end else begin
            return w[0];
        end
    endfunction

    // Drops the bit just sent so the next one sits in the outgoing position.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) begin
            return {w[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, w[WIDTH-1:1]};
        end
    endfunction

    assign accept_s = bus.din_valid & ~hold_full_q;

    // Next-state, shifter, holding-register and output computation.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        ser_out_d     = IDLE_BIT;
        ser_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        words_sent_d  = words_sent_q;
        load_s        = 1'b0;
        load_din_s    = 1'b0;
        take_hold_s   = 1'b0;
        load_word_s   = bus.din;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    load_s     = 1'b1;
                    load_din_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q != LAST_IDX) begin
                    ser_out_d   = first_bit(shift_q);
                    ser_valid_d = 1'b1;
                    shift_d     = advance(shift_q);
                    bit_cnt_d   = bit_cnt_q + CNT_W'(1);
                end else begin
                    words_sent_d = words_sent_q + 16'd1;
                    if (GAP > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = 4'd0;
                    end else if (hold_full_q) begin
                        load_s      = 1'b1;
                        take_hold_s = 1'b1;
                        load_word_s = hold_q;
                    end else if (accept_s) begin
                        load_s     = 1'b1;
                        load_din_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (hold_full_q) begin
                        load_s      = 1'b1;
                        take_hold_s = 1'b1;
                        load_word_s = hold_q;
                    end else if (accept_s) begin
                        load_s     = 1'b1;
                        load_din_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A load puts the first bit straight onto the registered output, so latency is one cycle.
        if (load_s) begin
            state_d       = ST_SHIFT;
            ser_out_d     = first_bit(load_word_s);
            ser_valid_d   = 1'b1;
            frame_start_d = 1'b1;
            shift_d       = advance(load_word_s);
            bit_cnt_d     = '0;
        end else begin
            shift_d = shift_d;
        end

        if (take_hold_s) begin
            hold_full_d = 1'b0;
        end else if (accept_s && !load_din_s) begin
            hold_d      = bus.din;
            hold_full_d = 1'b1;
        end else begin
            hold_full_d = hold_full_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            gap_cnt_q     <= 4'd0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            ser_out_q     <= IDLE_BIT;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            words_sent_q  <= 16'd0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
            words_sent_q  <= words_sent_d;
        end
    end

    assign bus.din_ready   = ~hold_full_q;
    assign bus.ser_out     = ser_out_q;
    assign bus.ser_valid   = ser_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.words_sent  = words_sent_q;
endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: two instances (MSB-first/no gap, LSB-first/GAP=3)
// checked every cycle against a word-timing model kept in the bench.
module tb_bit_serializer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bit_serializer_if #(.WIDTH(W)) bus0 ();
    bit_serializer_if #(.WIDTH(W)) bus1 ();

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave)
    );
    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .GAP(3)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave)
    );

    logic [W-1:0] din_s [2];
    logic         din_valid_s [2];
    logic         rdy_o [2];
    logic         sout_o [2];
    logic         sval_o [2];
    logic         frame_o [2];
    logic [15:0]  ws_o [2];

    assign bus0.din       = din_s[0];
    assign bus0.din_valid = din_valid_s[0];
    assign bus1.din       = din_s[1];
    assign bus1.din_valid = din_valid_s[1];
    assign rdy_o[0]   = bus0.din_ready;
    assign rdy_o[1]   = bus1.din_ready;
    assign sout_o[0]  = bus0.ser_out;
    assign sout_o[1]  = bus1.ser_out;
    assign sval_o[0]  = bus0.ser_valid;
    assign sval_o[1]  = bus1.ser_valid;
    assign frame_o[0] = bus0.frame_start;
    assign frame_o[1] = bus1.frame_start;
    assign ws_o[0]    = bus0.words_sent;
    assign ws_o[1]    = bus1.words_sent;

    // Model configuration of each instance.
    function automatic bit msb_of(input int i);
        return (i == 0);
    endfunction
    function automatic int gap_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    typedef struct {
        logic [W-1:0] w;
        int           start;
    } exp_t;

    exp_t        sb_q [2][$];
    int          last_end [2];
    bit          have_last [2];
    logic [15:0] sent_m [2];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, i, cyc, act, exp);
        end
    endtask

    // Monitor: cycle n shows the bits of the word whose start cycle is <= n; word start is
    // max(accept cycle + 1, previous word's last-bit cycle + 1 + GAP).
    always @(negedge clk) begin : monitor
        int           idx;
        int           st;
        logic         eb;
        logic         er;
        logic [W-1:0] wexp;
        if (cyc >= 1) begin
            for (int i = 0; i < 2; i++) begin
                er = 1'b1;
                for (int k = 0; k < sb_q[i].size(); k++) begin
                    if (sb_q[i][k].start > cyc) er = 1'b0;
                end
                check("din_ready", i, 32'(rdy_o[i]), 32'(er));
                check("words_sent", i, 32'(ws_o[i]), 32'(sent_m[i]));
                if (sb_q[i].size() > 0 && sb_q[i][0].start <= cyc) begin
                    idx  = cyc - sb_q[i][0].start;
                    wexp = sb_q[i][0].w;
                    eb   = msb_of(i) ? wexp[W-1-idx] : wexp[idx];
                    check("ser_valid", i, 32'(sval_o[i]), 32'd1);
                    check("ser_out", i, 32'(sout_o[i]), 32'(eb));
                    check("frame_start", i, 32'(frame_o[i]), (idx == 0) ? 32'd1 : 32'd0);
                    if (idx == W - 1) begin
                        void'(sb_q[i].pop_front());
                        sent_m[i] = sent_m[i] + 16'd1;
                    end
                end else begin
                    check("idle_valid", i, 32'(sval_o[i]), 32'd0);
                    check("idle_ser_out", i, 32'(sout_o[i]), 32'd0);
                    check("idle_frame", i, 32'(frame_o[i]), 32'd0);
                end
                if (reset) begin
                    sb_q[i].delete();
                    sent_m[i]    = 16'd0;
                    have_last[i] = 1'b0;
                end else if (din_valid_s[i] && rdy_o[i]) begin
                    st = cyc + 1;
                    if (have_last[i] && (last_end[i] + 1 + gap_of(i) > st)) begin
                        st = last_end[i] + 1 + gap_of(i);
                    end
                    sb_q[i].push_back('{din_s[i], st});
                    last_end[i]  = st + W - 1;
                    have_last[i] = 1'b1;
                end
            end
        end
    end

    task automatic send(input int i, input logic [W-1:0] w);
        int k;
        din_s[i]       = w;
        din_valid_s[i] = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rdy_o[i] && !reset) break;
        end
        if (k >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout dut%0d: got no din_ready, expected acceptance within 200 cycles", i);
        end else begin
            @(posedge clk);
            #1;
        end
        din_valid_s[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int k;
        k = 0;
        while (sb_q[i].size() != 0 && k < 400) begin
            @(posedge clk);
            k++;
        end
        if (k >= 400) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout dut%0d: got %0d words pending, expected 0", i, sb_q[i].size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic random_stream(input int i, input int count);
        int g;
        for (int n = 0; n < count; n++) begin
            send(i, W'($urandom));
            g = $urandom_range(0, 2);
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            din_s[i]       = '0;
            din_valid_s[i] = 1'b0;
            sent_m[i]      = 16'd0;
            have_last[i]   = 1'b0;
            last_end[i]    = 0;
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset during bit 4 of 8'hA5 while 8'h3C waits in the hold.
        send(0, 8'hA5);
        send(0, 8'h3C);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        send(0, 8'hB4);
        wait_idle(0);
        send(0, 8'hFF);
        send(0, 8'h00);
        wait_idle(0);

        send(1, 8'b0101_1010);
        wait_idle(1);
        send(1, 8'h81);
        send(1, 8'h7E);
        wait_idle(1);

        fork
            random_stream(0, 40);
            random_stream(1, 40);
        join
        wait_idle(0);
        wait_idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial front end for the serial sequence detector. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on ser_out, which drives the detector's serial input `ip`. A one-entry holding register lets the next word be accepted while the current word is shifting, so words stream back-to-back when GAP=0. Also provides a frame-start strobe and a running count of completed words.

Parameters:
WIDTH, 8, bits per word (2..32)
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first
IDLE_BIT, 0, value driven on ser_out whenever no data bit is being sent
GAP, 0, idle cycles inserted after each word (0..15)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
din  input  WIDTH  parallel word
din_valid  input  1  din holds a word
din_ready  output  1  block can take a word; transfer occurs on an edge where din_valid & din_ready
ser_out  output  1  serial bit; connects to the detector `ip`
ser_valid  output  1  ser_out carries a data bit this cycle
frame_start  output  1  high during the cycle the first bit of a word is on ser_out
words_sent  output  16  count of fully transmitted words

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high, sampled on the rising clk edge, and has priority over all other activity.
- Reset values: state=IDLE, hold empty, shifter cleared, ser_out=IDLE_BIT, ser_valid=0, frame_start=0, words_sent=0. din_ready=1 from the first cycle after reset deasserts.
- While reset is high, no transfer is accepted regardless of din_valid.
- din_ready = !hold_full. It is combinational from registered state only and never depends on din_valid.
- All of ser_out, ser_valid and frame_start are registered.
- States:
  - IDLE: no word in flight.
  - SHIFT: bit index 0..WIDTH-1.
  - GAP: gap counter 0..GAP-1.
- IDLE: an accepted word with hold empty bypasses the hold and loads the shifter directly. First bit appears on ser_out in the cycle after the accept edge (latency 1). frame_start=1 and ser_valid=1 in that cycle. Next state is SHIFT.
- SHIFT: one bit per cycle in MSB_FIRST order, with ser_valid=1.
- On the edge ending the last bit (index WIDTH-1):
  - words_sent increments, wrapping 65535 -> 0.
  - If GAP>0: go to GAP.
  - If GAP=0 and hold is full: load the shifter from hold, hold becomes empty, stay in SHIFT. The next cycle shows the new first bit with frame_start=1 and no bubble.
  - If GAP=0, hold is empty and a word is accepted on this same edge: bypass-load it, giving a back-to-back word.
  - Otherwise: go to IDLE.
- GAP: ser_out=IDLE_BIT and ser_valid=0 for exactly GAP cycles. At the end, load from hold (or take a same-edge accept when hold is empty) and go to SHIFT; otherwise go to IDLE.
- Accept while busy: while SHIFT or GAP with hold empty, an accepted word goes to hold, except in the same-edge bypass cases above.
- Hold full: din_ready=0, and din_valid is ignored.
- IDLE/GAP outputs: ser_out=IDLE_BIT, ser_valid=0, frame_start=0.
- Reset mid-word: the word in flight and the held word are discarded, not counted. Outputs return to reset values on the next cycle.
- Word order is preserved: the shifter always drains before the hold, and the hold before a new accept.

Test Plan:
- Reset then idle: reset=1 for 2 edges, release -> ser_out=0, ser_valid=0, din_ready=1, words_sent=0.
- Single word, MSB_FIRST=1: din=8'hB4 accepted at edge k -> over cycles k+1..k+8, ser_out=1,0,1,1,0,1,0,0 with ser_valid=1 throughout and frame_start=1 only at k+1. After that the block is IDLE and words_sent=1.
- Back-to-back, GAP=0: hold din_valid=1 with 8'hFF then 8'h00 -> 8 ones immediately followed by 8 zeros, no idle cycle; din_ready=0 while hold is full; words_sent=2.
- Detector pattern: with MSB_FIRST=0, din=8'b0101_1010 -> bit 0 is sent first, giving ser_out 0,1,0,1,1,0,1,0; the detector's op matches its own stimulus for the same bit stream.
- GAP=3: two words -> exactly 3 cycles of ser_valid=0 and ser_out=IDLE_BIT between the last bit of word 1 and frame_start of word 2.
- Reset mid-word: assert reset at bit 4 of 8'hA5 with 8'h3C held -> the next cycle shows ser_valid=0, din_ready=1 and words_sent unchanged; 8'h3C is never transmitted.
